// File: rtl/mem_ctrl.sv
`timescale 1ns/1ps
// mem_ctrl: arbitrates fetch and load/store word requests onto the byte-wide
// RAM / I/O bus, serialising each request into byte cycles and reassembling reads.
module mem_ctrl #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] IO_MASK    = 32'h00030000
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  if_req_valid,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_done,
    output logic [31:0]           if_data,
    input  logic                  ls_req_valid,
    input  logic                  ls_wr,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [1:0]            ls_size,
    input  logic [31:0]           ls_wdata,
    output logic                  ls_done,
    output logic [31:0]           ls_rdata,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  io_buffer_full
);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;      // READ: cycles since accept; WRITE: bytes issued
    logic [2:0]            size_q, size_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           buf_q, buf_d;
    logic                  src_ls_q, src_ls_d;

    logic [ADDR_WIDTH-1:0] mem_a_d;
    logic [7:0]            mem_dout_d;
    logic                  mem_wr_d;
    logic                  if_done_d, ls_done_d;
    logic [31:0]           if_data_d, ls_rdata_d;

    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [7:0]            wr_byte;
    logic                  wr_stall;
    logic [1:0]            cap_idx;
    logic [31:0]           assembled;

    function automatic logic [2:0] req_bytes(input logic [1:0] size);
        case (size)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic is_io(input logic [ADDR_WIDTH-1:0] a);
        return (a & IO_MASK) == IO_MASK;
    endfunction

    // Datapath helpers: next write byte, and the read word with this cycle's byte merged in.
    always_comb begin
        wr_addr   = base_q + ADDR_WIDTH'(cnt_q);
        wr_byte   = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
        wr_stall  = is_io(wr_addr) && io_buffer_full;
        cap_idx   = cnt_q[1:0] - 2'd1;
        assembled = buf_q;
        assembled[{cap_idx, 3'b000} +: 8] = mem_din;
    end

    // NOTE: every signal written here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        size_d     = size_q;
        base_d     = base_q;
        wdata_d    = wdata_q;
        buf_d      = buf_q;
        src_ls_d   = src_ls_q;
        mem_a_d    = mem_a;
        mem_dout_d = mem_dout;
        mem_wr_d   = 1'b0;
        if_done_d  = 1'b0;
        ls_done_d  = 1'b0;
        if_data_d  = if_data;
        ls_rdata_d = ls_rdata;

        case (state_q)
            IDLE: begin
                mem_a_d    = '0;
                mem_dout_d = '0;
                // A requester still shows valid in its own done cycle; skip that cycle.
                if (!if_done && !ls_done && (ls_req_valid || if_req_valid)) begin
                    src_ls_d = ls_req_valid;
                    base_d   = ls_req_valid ? ls_addr : if_addr;
                    size_d   = ls_req_valid ? req_bytes(ls_size) : 3'd4;
                    wdata_d  = ls_wdata;
                    buf_d    = '0;
                    mem_a_d  = base_d;
                    cnt_d    = 3'd0;
                    if (ls_req_valid && ls_wr) begin
                        state_d    = WRITE;
                        mem_dout_d = ls_wdata[7:0];
                        if (!(is_io(ls_addr) && io_buffer_full)) begin
                            mem_wr_d = 1'b1;
                            cnt_d    = 3'd1;
                        end
                    end else begin
                        state_d = READ;
                    end
                end
            end

            READ: begin
                if (cnt_q + 3'd1 < size_q) begin
                    mem_a_d = base_q + ADDR_WIDTH'(cnt_q + 3'd1);
                end
                if (cnt_q != 3'd0) begin
                    buf_d = assembled;
                end
                if (cnt_q == size_q) begin
                    state_d = IDLE;
                    mem_a_d = '0;
                    if (src_ls_q) begin
                        ls_done_d  = 1'b1;
                        ls_rdata_d = assembled;
                    end else begin
                        if_done_d = 1'b1;
                        if_data_d = assembled;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end

            WRITE: begin
                if (cnt_q == size_q) begin
                    state_d    = IDLE;
                    ls_done_d  = 1'b1;
                    mem_a_d    = '0;
                    mem_dout_d = '0;
                end else begin
                    mem_a_d    = wr_addr;
                    mem_dout_d = wr_byte;
                    if (!wr_stall) begin
                        mem_wr_d = 1'b1;
                        cnt_d    = cnt_q + 3'd1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            size_q   <= '0;
            base_q   <= '0;
            wdata_q  <= '0;
            buf_q    <= '0;
            src_ls_q <= 1'b0;
            mem_a    <= '0;
            mem_dout <= '0;
            mem_wr   <= 1'b0;
            if_done  <= 1'b0;
            ls_done  <= 1'b0;
            if_data  <= '0;
            ls_rdata <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            size_q   <= size_d;
            base_q   <= base_d;
            wdata_q  <= wdata_d;
            buf_q    <= buf_d;
            src_ls_q <= src_ls_d;
            mem_a    <= mem_a_d;
            mem_dout <= mem_dout_d;
            mem_wr   <= mem_wr_d;
            if_done  <= if_done_d;
            ls_done  <= ls_done_d;
            if_data  <= if_data_d;
            ls_rdata <= ls_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for mem_ctrl: byte RAM environment, a byte-array reference
// model, a directed vector table, hand-written corner sequences and random traffic.
module tb_mem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        if_req_valid;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        ls_req_valid;
    logic        ls_wr;
    logic [31:0] ls_addr;
    logic [1:0]  ls_size;
    logic [31:0] ls_wdata;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] ram     [0:131071];   // environment RAM driven by the DUT pins
    logic [7:0] ref_mem [0:131071];   // expected memory contents

    mem_ctrl dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .if_req_valid   (if_req_valid),
        .if_addr        (if_addr),
        .if_done        (if_done),
        .if_data        (if_data),
        .ls_req_valid   (ls_req_valid),
        .ls_wr          (ls_wr),
        .ls_addr        (ls_addr),
        .ls_size        (ls_size),
        .ls_wdata       (ls_wdata),
        .ls_done        (ls_done),
        .ls_rdata       (ls_rdata),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full)
    );

    always #5 clk_in = ~clk_in;

    // 1-cycle synchronous-read RAM, using the low 17 address bits.
    always @(posedge clk_in) begin
        if (mem_wr) ram[mem_a[16:0]] <= mem_dout;
        mem_din <= ram[mem_a[16:0]];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [16:0] ram_idx(input logic [31:0] a);
        return a[16:0];
    endfunction

    function automatic bit is_io(input logic [31:0] a);
        return (a & 32'h0003_0000) == 32'h0003_0000;
    endfunction

    function automatic bit io_at(input logic [15:0] p, input int i);
        return (i >= 0 && i < 16) ? p[i] : 1'b0;
    endfunction

    // Runs one request from an idle, non-done cycle A (the current negedge).
    // io_pat[i] is io_buffer_full during cycle A+i. Pins are predicted from the
    // byte-by-byte rules: reads show byte t-1 in cycle A+t and finish at A+N+2;
    // a write byte goes out unless it is an I/O byte and io_buffer_full was high
    // the cycle before, and ls_done follows the last issued byte by one cycle.
    task automatic run_req(input bit is_ls, input bit wr, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [15:0] io_pat, input string tag,
                           output int lat, output logic [31:0] got);
        int          n, j, last_issue;
        bit          exp_done, fin;
        logic [31:0] a, exp_word;
        n = !is_ls ? 4 : (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        exp_word = '0;
        for (int b = 0; b < n; b++) exp_word[8*b +: 8] = ref_mem[ram_idx(addr + 32'(b))];

        if_req_valid   = !is_ls;
        if_addr        = addr;
        ls_req_valid   = is_ls;
        ls_wr          = is_ls && wr;
        ls_addr        = addr;
        ls_size        = size;
        ls_wdata       = wdata;
        io_buffer_full = io_pat[0];

        j = 0; last_issue = -10; lat = -1; got = '0; fin = 1'b0;
        for (int t = 1; t <= 40 && !fin; t++) begin
            @(negedge clk_in);
            if (wr) begin
                if (j < n) begin
                    a = addr + 32'(j);
                    if (is_io(a) && io_at(io_pat, t - 1)) begin
                        check($sformatf("%s stall mem_wr t=%0d", tag, t), 32'(mem_wr), 32'd0);
                    end else begin
                        check($sformatf("%s mem_wr t=%0d", tag, t), 32'(mem_wr), 32'd1);
                        check($sformatf("%s mem_a t=%0d", tag, t), mem_a, a);
                        check($sformatf("%s mem_dout t=%0d", tag, t), 32'(mem_dout), 32'(wdata[8*j +: 8]));
                        j++;
                        if (j == n) last_issue = t;
                    end
                end else begin
                    check($sformatf("%s extra mem_wr t=%0d", tag, t), 32'(mem_wr), 32'd0);
                end
                exp_done = (t == last_issue + 1);
            end else begin
                if (t <= n) begin
                    check($sformatf("%s rd mem_wr t=%0d", tag, t), 32'(mem_wr), 32'd0);
                    check($sformatf("%s rd mem_a t=%0d", tag, t), mem_a, addr + 32'(t - 1));
                end
                exp_done = (t == n + 2);
            end
            check($sformatf("%s done t=%0d", tag, t), 32'(is_ls ? ls_done : if_done), 32'(exp_done));
            check($sformatf("%s other done t=%0d", tag, t), 32'(is_ls ? if_done : ls_done), 32'd0);
            if (exp_done) begin
                lat = t;
                got = is_ls ? ls_rdata : if_data;
                if (!wr) check($sformatf("%s data", tag), got, exp_word);
                fin = 1'b1;
                if_req_valid = 1'b0;
                ls_req_valid = 1'b0;
            end
            io_buffer_full = io_at(io_pat, t);
        end
        check($sformatf("%s completed within bound", tag), 32'(fin), 32'd1);
        if (wr) for (int b = 0; b < n; b++) ref_mem[ram_idx(addr + 32'(b))] = wdata[8*b +: 8];
        if_req_valid   = 1'b0;
        ls_req_valid   = 1'b0;
        io_buffer_full = 1'b0;
        @(negedge clk_in);
    endtask

    typedef struct {
        bit          is_ls;
        bit          wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [15:0] io_pat;
        int          exp_lat;
        bit          chk_data;
        logic [31:0] exp_data;
        string       name;
    } vec_t;

    function automatic vec_t mk(input bit is_ls, input bit wr, input logic [1:0] size,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [15:0] io_pat, input int exp_lat,
                                input bit chk_data, input logic [31:0] exp_data,
                                input string name);
        vec_t v;
        v.is_ls = is_ls; v.wr = wr; v.size = size; v.addr = addr; v.wdata = wdata;
        v.io_pat = io_pat; v.exp_lat = exp_lat; v.chk_data = chk_data;
        v.exp_data = exp_data; v.name = name;
        return v;
    endfunction

    vec_t        vecs [11];
    int          lat, ls_t, if_t;
    logic [31:0] got, ls_seen;
    bit          r_ls, r_wr;
    logic [1:0]  r_sz;
    logic [31:0] r_ad, r_wd;
    logic [15:0] r_io;

    initial begin
        // Directed vectors: {request, io pattern, expected done cycle, expected data}.
        vecs[0]  = mk(0, 0, 2'd2, 32'h0000_0100, 32'h0,         16'h0000, 6, 1, 32'h0000_0513, "fetch_100");
        vecs[1]  = mk(1, 1, 2'd2, 32'h0000_0200, 32'hDEAD_BEEF, 16'h0000, 5, 0, 32'h0,         "store_w_200");
        vecs[2]  = mk(1, 0, 2'd1, 32'h0000_0202, 32'h0,         16'h0000, 4, 1, 32'h0000_DEAD, "load_h_202");
        vecs[3]  = mk(1, 0, 2'd3, 32'h0000_0200, 32'h0,         16'h0000, 6, 1, 32'hDEAD_BEEF, "load_size3");
        vecs[4]  = mk(1, 0, 2'd0, 32'h0000_0203, 32'h0,         16'h0000, 3, 1, 32'h0000_00DE, "load_b_203");
        vecs[5]  = mk(1, 1, 2'd2, 32'hFFFF_FFFE, 32'h1122_3344, 16'h0000, 5, 0, 32'h0,         "store_wrap");
        vecs[6]  = mk(1, 0, 2'd2, 32'hFFFF_FFFE, 32'h0,         16'h0000, 6, 1, 32'h1122_3344, "load_wrap");
        vecs[7]  = mk(1, 1, 2'd0, 32'h0003_0000, 32'h0000_0041, 16'h0007, 5, 0, 32'h0,         "io_store_stall");
        vecs[8]  = mk(1, 0, 2'd0, 32'h0003_0000, 32'h0,         16'hFFFF, 3, 1, 32'h0000_0041, "io_load_nostall");
        vecs[9]  = mk(1, 1, 2'd1, 32'h0003_0001, 32'h0000_A55A, 16'h0002, 4, 0, 32'h0,         "io_half_midstall");
        vecs[10] = mk(1, 0, 2'd1, 32'h0003_0001, 32'h0,         16'h0000, 4, 1, 32'h0000_A55A, "io_half_load");

        for (int i = 0; i < 131072; i++) begin
            logic [7:0] v;
            v = 8'($urandom);
            ram[i] <= v;
            ref_mem[i] = v;
        end
        ram[17'h100] <= 8'h13; ram[17'h101] <= 8'h05; ram[17'h102] <= 8'h00; ram[17'h103] <= 8'h00;
        ram[17'h010] <= 8'h80;
        ref_mem[17'h100] = 8'h13; ref_mem[17'h101] = 8'h05; ref_mem[17'h102] = 8'h00; ref_mem[17'h103] = 8'h00;
        ref_mem[17'h010] = 8'h80;

        rst_in = 1'b1; if_req_valid = 1'b0; if_addr = '0; ls_req_valid = 1'b0; ls_wr = 1'b0;
        ls_addr = '0; ls_size = '0; ls_wdata = '0; io_buffer_full = 1'b0;
        repeat (3) @(negedge clk_in);
        check("reset mem_a", mem_a, 32'h0);
        check("reset mem_wr", 32'(mem_wr), 32'h0);
        check("reset mem_dout", 32'(mem_dout), 32'h0);
        check("reset if_done", 32'(if_done), 32'h0);
        check("reset ls_done", 32'(ls_done), 32'h0);
        check("reset if_data", if_data, 32'h0);
        check("reset ls_rdata", ls_rdata, 32'h0);
        rst_in = 1'b0;
        @(negedge clk_in);

        for (int i = 0; i < 11; i++) begin
            run_req(vecs[i].is_ls, vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata,
                    vecs[i].io_pat, vecs[i].name, lat, got);
            check($sformatf("%s done cycle", vecs[i].name), 32'(lat), 32'(vecs[i].exp_lat));
            if (vecs[i].chk_data) check($sformatf("%s table data", vecs[i].name), got, vecs[i].exp_data);
        end

        // Both requests rise together: byte load wins, fetch is accepted at A+4.
        ls_req_valid = 1'b1; ls_wr = 1'b0; ls_size = 2'd0; ls_addr = 32'h10;
        if_req_valid = 1'b1; if_addr = 32'h100;
        ls_t = -1; if_t = -1; ls_seen = '0;
        for (int t = 1; t <= 20 && if_t < 0; t++) begin
            @(negedge clk_in);
            if (t == 1) check("arb first mem_a", mem_a, 32'h10);
            if (t == 5) check("arb fetch mem_a", mem_a, 32'h100);
            if (ls_done && ls_t < 0) begin ls_t = t; ls_seen = ls_rdata; ls_req_valid = 1'b0; end
            if (if_done) begin if_t = t; if_req_valid = 1'b0; end
        end
        check("arb ls_done cycle", 32'(ls_t), 32'd3);
        check("arb ls_rdata", ls_seen, 32'h0000_0080);
        check("arb if_done cycle", 32'(if_t), 32'd10);
        check("arb if_data", if_data, 32'h0000_0513);
        check("arb ls_rdata held", ls_rdata, 32'h0000_0080);
        if_req_valid = 1'b0; ls_req_valid = 1'b0;
        @(negedge clk_in);

        // Reset pulsed in cycle A+3 of a word fetch.
        if_req_valid = 1'b1; if_addr = 32'h200;
        repeat (3) @(negedge clk_in);
        rst_in = 1'b1; if_req_valid = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b0;
        check("midrst mem_a", mem_a, 32'h0);
        check("midrst mem_wr", 32'(mem_wr), 32'h0);
        check("midrst mem_dout", 32'(mem_dout), 32'h0);
        check("midrst if_done", 32'(if_done), 32'h0);
        check("midrst ls_done", 32'(ls_done), 32'h0);
        check("midrst if_data", if_data, 32'h0);
        check("midrst ls_rdata", ls_rdata, 32'h0);
        for (int t = 5; t <= 12; t++) begin
            @(negedge clk_in);
            check($sformatf("midrst no if_done t=%0d", t), 32'(if_done), 32'h0);
            check($sformatf("midrst no mem_wr t=%0d", t), 32'(mem_wr), 32'h0);
        end
        run_req(1'b0, 1'b0, 2'd2, 32'h100, 32'h0, 16'h0, "fetch_after_rst", lat, got);
        check("fetch_after_rst done cycle", 32'(lat), 32'd6);
        check("fetch_after_rst data", got, 32'h0000_0513);

        // Random traffic against the reference memory.
        for (int r = 0; r < 200; r++) begin
            r_ls = ($urandom_range(0, 3) != 0);
            r_wr = r_ls && ($urandom_range(0, 1) == 1);
            r_sz = 2'($urandom_range(0, 3));
            r_ad = $urandom;
            case ($urandom_range(0, 3))
                0:       r_ad = r_ad & 32'h0000_03FF;
                1:       r_ad = (r_ad & 32'hFFFC_00FF) | 32'h0003_0000;
                2:       r_ad = 32'hFFFF_FFF8 | (r_ad & 32'h7);
                default: r_ad = r_ad;
            endcase
            r_wd = $urandom;
            r_io = 16'($urandom);
            if ($urandom_range(0, 1) == 1) r_io = r_io & 16'($urandom);
            run_req(r_ls, r_wr, r_sz, r_ad, r_wd, r_io, $sformatf("rnd%0d", r), lat, got);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
